display_pattern_gen: RTL and testbench
======================================

Name: display_pattern_gen

Overview:
Upstream feeder for the HDMI LED/segment display renderer. Generates the 16-bit red_leds, 16-bit green_leds and 32-bit segments words from two raw push-buttons and a frame-rate tick, all in the video clock domain. Provides three selectable LED animations and an 8-digit BCD run counter that drives the segment display.

Parameters:
TICK_DIV, 740000, video-clock cycles per animation tick (74 MHz / 100 Hz = 10 ms); legal range 2..2^24-1
DEBOUNCE_TICKS, 2, consecutive ticks a key sample must hold before the debounced state changes; legal range 1..15

Ports:
clk_video  in  1  video pixel clock
reset_n  in  1  asynchronous active-low reset
key_mode  in  1  raw mode button, active-low, asynchronous to clk_video
key_run  in  1  raw run/pause button, active-low, asynchronous to clk_video
red_leds  out  16  red LED pattern to the display renderer
green_leds  out  16  green LED pattern to the display renderer
segments  out  32  8 BCD digits; digit 0 in [3:0], digit 7 in [31:28]
mode  out  2  current animation mode (0, 1 or 2)
running  out  1  1 = animation and BCD counter advance
tick  out  1  one-cycle animation tick pulse

Behaviour:
- Reset (reset_n=0, async assert; deassertion takes effect on the next clk_video edge): all outputs 0 except running=1; prescaler 0; synchronizer and debounce state = released (1); cnt=0, pos=0, dir=up, lvl=0, BCD=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for exactly one cycle when the count equals TICK_DIV-1, so ticks are TICK_DIV cycles apart.
- Key input path: 2-FF synchronizer per key, then a debouncer sampled only on tick cycles.
  - A per-key stable counter increments while the sample differs from the debounced state and clears when it matches.
  - When the stable counter reaches DEBOUNCE_TICKS, the debounced state flips.
  - A 1->0 flip produces a one-cycle press pulse on the cycle after that tick. Release generates no event.
- run_press toggles running. mode_press advances mode 0->1->2->0. Mode 3 is unreachable; if it is ever seen, it is treated as 0 on the next press.
- Pattern state advances only on cycles where tick=1 and running=1:
  - Mode 0 BINARY: cnt = cnt+1, mod 2^16.
  - Mode 1 SCANNER: pos moves one position in the current direction. When pos reaches 15 going up, dir flips to down; when pos reaches 0 going down, dir flips to up. The end positions are shown once, so the sequence is ...14,15,14,... and ...1,0,1,...
  - Mode 2 FILL: lvl = lvl+1 over 0..16. Level 16 is followed by 0.
- On mode_press, cnt, pos, dir and lvl reset to their reset values in the same cycle that mode updates. The BCD counter and running are unaffected.
- Priority in a single cycle: mode_press over step. Any step that coincides with a mode_press is discarded.
- BCD counter: 8 decimal digits, increments on tick & running regardless of mode.
  - Per-digit carry: a digit at 9 goes to 0 and carries into the next digit.
  - 99999999 wraps to 00000000.
  - Toggling running pauses and resumes without loss.
- Outputs are registered and computed each cycle from the state of the previous cycle (1-cycle latency):
  - Mode 0: red = cnt, green = ~cnt.
  - Mode 1: red = 1<<pos, green = 1<<(15-pos).
  - Mode 2: red = (2^lvl)-1 (lvl 16 gives 0xFFFF), green = ~red.
  - segments = BCD digits.
  - mode and running reflect their registers directly.
- The first cycle after reset deasserts in mode 0 gives red=0x0000 and green=0xFFFF.
- Reset asserted mid-operation clears everything immediately. There are no partial press events after release of reset, because the synchronizers restart from the released state.

Test Plan:
- TICK_DIV=4, no keys pressed, 40 cycles -> tick every 4th cycle; red counts 0,1,2,...,9 across 10 ticks; green=~red; segments=0x00000010 after 10 ticks.
- DEBOUNCE_TICKS=2: key_mode low for 1 tick, then high -> no mode change. Key_mode low for 3 ticks -> exactly one press; mode 0->1 with red=0x0001, green=0x8000; three presses total return mode to 0.
- Mode 1, 32 ticks -> pos sequence 0..15..0 then 1; red=0x8000 at tick 15 and 0x0001 at tick 30.
- Mode 2, 17 ticks -> red goes 0x0000,0x0001,0x0003,...,0xFFFF,0x0000; green complementary.
- key_run press -> running=0; cnt and BCD frozen for 10 ticks. Second press resumes from the same values.
- BCD preloaded by forcing 99999999, one tick -> segments=0x00000000. Reset_n pulsed low mid-animation -> all outputs 0 within the same cycle, running=1.

Source files
------------

// File: rtl/display_pattern_gen.sv
// display_pattern_gen: LED/segment pattern source for the HDMI display renderer.
// Keys are synchronized and debounced on animation ticks. Three LED animations
// (binary count, scanner, fill) and an 8-digit BCD run counter advance on each
// tick while running. All outputs are registered with one cycle of latency.
module display_pattern_gen #(
  parameter int TICK_DIV       = 740000,
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic        clk_video,
  input  logic        reset_n,
  input  logic        key_mode,
  input  logic        key_run,
  output logic [15:0] red_leds,
  output logic [15:0] green_leds,
  output logic [31:0] segments,
  output logic [1:0]  mode,
  output logic        running,
  output logic        tick
);

  localparam logic [23:0] PRESC_LAST = 24'(TICK_DIV - 1);
  localparam logic [3:0]  DEB_LAST   = 4'(DEBOUNCE_TICKS);

  localparam logic [1:0] MODE_BINARY  = 2'd0;
  localparam logic [1:0] MODE_SCANNER = 2'd1;
  localparam logic [1:0] MODE_FILL    = 2'd2;

  // Key index 0 = mode button, 1 = run button (both active-low)
  logic [1:0]      keys_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0][3:0] stab_q, stab_d;
  logic [1:0]      press_q, press_d;

  logic [23:0] presc_q, presc_d;
  logic        tick_q, tick_d;

  logic [1:0]  mode_q, mode_d;
  logic        running_q, running_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  pos_q, pos_d;
  logic        dir_q, dir_d;      // 0 = moving up, 1 = moving down
  logic [4:0]  lvl_q, lvl_d;
  logic [31:0] bcd_q, bcd_d;
  logic        step;

  logic [15:0] red_q, red_d;
  logic [15:0] green_q, green_d;
  logic [31:0] seg_q;

  assign keys_raw = {key_run, key_mode};
  assign step     = tick_q & running_q;

  // Increment an 8-digit packed BCD value; 99999999 rolls over to 0
  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Fill bar: lowest lvl bits set; level 16 lights every LED
  function automatic logic [15:0] fill_mask(input logic [4:0] lvl);
    logic [16:0] m;
    m = (17'd1 << lvl) - 17'd1;
    return m[15:0];
  endfunction

  // Prescaler wrap and registered tick aligned with count == TICK_DIV-1
  always_comb begin
    presc_d = (presc_q == PRESC_LAST) ? 24'd0 : presc_q + 24'd1;
    tick_d  = (presc_d == PRESC_LAST);
  end

  // Debouncer: a differing sample must persist DEB_LAST ticks to flip the state
  always_comb begin
    deb_d   = deb_q;
    stab_d  = stab_q;
    press_d = 2'b00;
    if (tick_q) begin
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] != deb_q[k]) begin
          if (stab_q[k] + 4'd1 == DEB_LAST) begin
            deb_d[k]   = sync2_q[k];
            stab_d[k]  = 4'd0;
            press_d[k] = ~sync2_q[k];
          end else begin
            stab_d[k] = stab_q[k] + 4'd1;
          end
        end else begin
          stab_d[k] = 4'd0;
        end
      end
    end
  end

  // Run/mode control and pattern stepping; a mode press wins over a step
  always_comb begin
    mode_d    = mode_q;
    running_d = running_q ^ press_q[1];
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    lvl_d     = lvl_q;
    bcd_d     = step ? bcd_inc(bcd_q) : bcd_q;
    if (press_q[0]) begin
      case (mode_q)
        MODE_BINARY:  mode_d = MODE_SCANNER;
        MODE_SCANNER: mode_d = MODE_FILL;
        default:      mode_d = MODE_BINARY;
      endcase
      cnt_d = 16'd0;
      pos_d = 4'd0;
      dir_d = 1'b0;
      lvl_d = 5'd0;
    end else if (step) begin
      case (mode_q)
        MODE_BINARY: cnt_d = cnt_q + 16'd1;
        MODE_SCANNER: begin
          if (!dir_q) begin
            pos_d = pos_q + 4'd1;
            if (pos_q == 4'd14) dir_d = 1'b1;
          end else begin
            pos_d = pos_q - 4'd1;
            if (pos_q == 4'd1) dir_d = 1'b0;
          end
        end
        MODE_FILL: lvl_d = (lvl_q == 5'd16) ? 5'd0 : lvl_q + 5'd1;
        default: ;
      endcase
    end
  end

  // LED words derived from the current pattern state
  always_comb begin
    red_d   = cnt_q;
    green_d = ~cnt_q;
    case (mode_q)
      MODE_SCANNER: begin
        red_d   = 16'd1 << pos_q;
        green_d = 16'd1 << (4'd15 - pos_q);
      end
      MODE_FILL: begin
        red_d   = fill_mask(lvl_q);
        green_d = ~fill_mask(lvl_q);
      end
      default: ;
    endcase
  end

  // State and output registers; synchronizers restart in the released state
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= 24'd0;
      tick_q    <= 1'b0;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;
      stab_q    <= '0;
      press_q   <= 2'b00;
      mode_q    <= MODE_BINARY;
      running_q <= 1'b1;
      cnt_q     <= 16'd0;
      pos_q     <= 4'd0;
      dir_q     <= 1'b0;
      lvl_q     <= 5'd0;
      bcd_q     <= 32'd0;
      red_q     <= 16'd0;
      green_q   <= 16'd0;
      seg_q     <= 32'd0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      stab_q    <= stab_d;
      press_q   <= press_d;
      mode_q    <= mode_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      lvl_q     <= lvl_d;
      bcd_q     <= bcd_d;
      red_q     <= red_d;
      green_q   <= green_d;
      seg_q     <= bcd_q;
    end
  end

  assign red_leds   = red_q;
  assign green_leds = green_q;
  assign segments   = seg_q;
  assign mode       = mode_q;
  assign running    = running_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_display_pattern_gen.sv
// Directed bench for display_pattern_gen with TICK_DIV=4, DEBOUNCE_TICKS=2.
module tb_display_pattern_gen;

  logic        clk;
  logic        rst_n;
  logic        key_mode;
  logic        key_run;
  logic [15:0] red_leds;
  logic [15:0] green_leds;
  logic [31:0] segments;
  logic [1:0]  mode;
  logic        running;
  logic        tick;

  int checks   = 0;
  int failures = 0;

  display_pattern_gen #(.TICK_DIV(4), .DEBOUNCE_TICKS(2)) dut (
    .clk_video (clk),
    .reset_n   (rst_n),
    .key_mode  (key_mode),
    .key_run   (key_run),
    .red_leds  (red_leds),
    .green_leds(green_leds),
    .segments  (segments),
    .mode      (mode),
    .running   (running),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge inside the next tick cycle (bounded wait)
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 8);
    check("tick_wait", {31'd0, tick}, 32'd1);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // Hold a key low for exactly k debounce samples, then release it
  task automatic hold_key(input bit is_run, input int k);
    if (is_run) key_run = 1'b0;
    else        key_mode = 1'b0;
    repeat (k) next_tick();
    key_run  = 1'b1;
    key_mode = 1'b1;
  endtask

  task automatic check_leds(input string tag, input logic [15:0] r, input logic [15:0] g);
    check({tag, "_red"},   {16'd0, red_leds},   {16'd0, r});
    check({tag, "_green"}, {16'd0, green_leds}, {16'd0, g});
  endtask

  initial begin
    logic [15:0] e;
    int          p;
    int          lv;
    rst_n    = 1'b0;
    key_mode = 1'b1;
    key_run  = 1'b1;
    repeat (2) @(negedge clk);
    check_leds("rst", 16'h0000, 16'h0000);
    check("rst_seg",  segments, 32'h0);
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_run",  {31'd0, running}, 32'd1);
    check("rst_tick", {31'd0, tick}, 32'd0);

    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check("tick_phase", {31'd0, tick}, {31'd0, (c % 4 == 3)});
      if (c == 1) check_leds("first", 16'h0000, 16'hFFFF);
    end
    check("bin9_red", {16'd0, red_leds}, 32'd9);
    check("bin9_seg", segments, 32'h9);
    @(negedge clk);
    check_leds("bin10", 16'd10, 16'hFFF5);
    check("bin10_seg", segments, 32'h10);

    // Pause, stay frozen, then resume
    next_tick();
    hold_key(1'b1, 3);
    check("pause_run", {31'd0, running}, 32'd0);
    check_leds("pause", 16'd13, 16'hFFF2);
    check("pause_seg", segments, 32'h13);
    repeat (10) next_tick();
    check("frozen_red", {16'd0, red_leds}, 32'd13);
    check("frozen_seg", segments, 32'h13);
    check("frozen_run", {31'd0, running}, 32'd0);
    hold_key(1'b1, 3);
    check("resume_run", {31'd0, running}, 32'd1);
    check("resume_red", {16'd0, red_leds}, 32'd13);
    settle();
    check_leds("resumed", 16'd14, 16'hFFF1);
    check("resumed_seg", segments, 32'h14);

    // Glitch of one sample is rejected
    next_tick();
    hold_key(1'b0, 1);
    repeat (2) next_tick();
    check("glitch_mode", {30'd0, mode}, 32'd0);
    check("glitch_red", {16'd0, red_leds}, 32'd17);

    // Mode 1 scanner
    hold_key(1'b0, 3);
    check("m1_mode", {30'd0, mode}, 32'd1);
    check_leds("m1_start", 16'h0001, 16'h8000);
    for (int i = 1; i <= 31; i++) begin
      settle();
      p = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
      e = 16'h0001 << p;
      check_leds("scan", e, 16'h0001 << (15 - p));
      next_tick();
    end

    // Mode 2 fill
    hold_key(1'b0, 3);
    check("m2_mode", {30'd0, mode}, 32'd2);
    check_leds("m2_start", 16'h0000, 16'hFFFF);
    for (int i = 1; i <= 17; i++) begin
      settle();
      lv = i % 17;
      e = (lv == 16) ? 16'hFFFF : 16'((32'd1 << lv) - 32'd1);
      check_leds("fill", e, ~e);
      next_tick();
    end

    // Third press returns to mode 0
    hold_key(1'b0, 3);
    check("m0_mode", {30'd0, mode}, 32'd0);
    check_leds("m0_start", 16'h0000, 16'hFFFF);

    // BCD rollover from 99999999
    @(negedge clk);
    force dut.bcd_q = 32'h99999999;
    @(negedge clk);
    release dut.bcd_q;
    check("bcd_max_seg", segments, 32'h99999999);
    next_tick();
    check("bcd_hold_seg", segments, 32'h99999999);
    settle();
    check("bcd_wrap_seg", segments, 32'h00000000);
    next_tick();
    settle();
    check("bcd_one_seg", segments, 32'h00000001);
    check_leds("pre_rst", 16'd3, 16'hFFFC);

    // Asynchronous reset mid-animation
    rst_n = 1'b0;
    #1;
    check_leds("mid_rst", 16'h0000, 16'h0000);
    check("mid_rst_seg",  segments, 32'h0);
    check("mid_rst_mode", {30'd0, mode}, 32'd0);
    check("mid_rst_run",  {31'd0, running}, 32'd1);
    check("mid_rst_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_leds("post_rst", 16'h0000, 16'hFFFF);
    check("post_rst_tick", {31'd0, tick}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
